// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line-follow motion sequencer.
package line_follow_pkg;

  localparam int SPEED_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAMP   = 3'd1,
    ST_FOLLOW = 3'd2,
    ST_SEARCH = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [1:0] POS_NONE  = 2'b00;
  localparam logic [1:0] POS_LEFT  = 2'b01;
  localparam logic [1:0] POS_RIGHT = 2'b10;
  localparam logic [1:0] POS_BOTH  = 2'b11;

  function automatic logic [SPEED_W-1:0] min_speed(
    input logic [SPEED_W-1:0] a,
    input logic [SPEED_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/line_follow_sequencer_limiter.sv
// Soft-start speed limit: loadable, steps with saturation,
// and clamps both speed channels to the current limit.
module speed_ramp_limiter
  import line_follow_pkg::*;
#(
  parameter logic [SPEED_W-1:0] MAX_SPEED = 8'd50,
  parameter logic [SPEED_W-1:0] RAMP_STEP = 8'd5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               load,
  input  logic [SPEED_W-1:0] load_val,
  input  logic [SPEED_W-1:0] cmd_left,
  input  logic [SPEED_W-1:0] cmd_right,
  output logic [SPEED_W-1:0] limit,
  output logic [SPEED_W-1:0] lim_left,
  output logic [SPEED_W-1:0] lim_right
);

  // one extra bit so the step can never wrap past the target
  logic [SPEED_W:0] sum;

  assign sum = {1'b0, limit} + {1'b0, RAMP_STEP};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit <= '0;
    end else if (load) begin
      limit <= load_val;
    end else if (step) begin
      if (sum >= {1'b0, MAX_SPEED})
        limit <= MAX_SPEED;
      else
        limit <= sum[SPEED_W-1:0];
    end
  end

  assign lim_left  = min_speed(cmd_left, limit);
  assign lim_right = min_speed(cmd_right, limit);

endmodule

// File: rtl/line_follow_sequencer.sv
// Motion sequencer: ramp, follow, search spin and halt
// control in front of the PWM stage.
module line_follow_sequencer
  import line_follow_pkg::*;
#(
  parameter logic [SPEED_W-1:0] MAX_SPEED    = 8'd50,
  parameter logic [SPEED_W-1:0] RAMP_STEP    = 8'd5,
  parameter logic [SPEED_W-1:0] SEARCH_SPEED = 8'd30,
  parameter logic [15:0]        LOST_TICKS   = 16'd20,
  parameter logic [15:0]        SEARCH_TICKS = 16'd500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               stop_req,
  input  logic [1:0]         position,
  input  logic [SPEED_W-1:0] cmd_left,
  input  logic [SPEED_W-1:0] cmd_right,
  output logic [SPEED_W-1:0] motor_left,
  output logic [SPEED_W-1:0] motor_right,
  output logic [2:0]         state_o,
  output logic               lost_flag
);

  state_t             state, state_next;
  dir_t               last_dir, dir_next;
  logic [15:0]        lost_cnt, lost_next;
  logic [15:0]        search_cnt, search_next;
  logic               flag_next;
  logic               lim_load, lim_step;
  logic [SPEED_W-1:0] lim_val, limit;
  logic [SPEED_W-1:0] lim_left, lim_right;
  logic [SPEED_W-1:0] ml_next, mr_next;

  speed_ramp_limiter #(
    .MAX_SPEED(MAX_SPEED),
    .RAMP_STEP(RAMP_STEP)
  ) u_limiter (
    .clk      (clk),
    .reset    (reset),
    .step     (lim_step),
    .load     (lim_load),
    .load_val (lim_val),
    .cmd_left (cmd_left),
    .cmd_right(cmd_right),
    .limit    (limit),
    .lim_left (lim_left),
    .lim_right(lim_right)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_dir    <= DIR_LEFT;
      lost_cnt    <= '0;
      search_cnt  <= '0;
      lost_flag   <= 1'b0;
      motor_left  <= '0;
      motor_right <= '0;
    end else begin
      state       <= state_next;
      last_dir    <= dir_next;
      lost_cnt    <= lost_next;
      search_cnt  <= search_next;
      lost_flag   <= flag_next;
      motor_left  <= ml_next;
      motor_right <= mr_next;
    end
  end

  // motor drive follows the state the cycle was spent in
  always_comb begin
    ml_next = '0;
    mr_next = '0;
    case (state)
      ST_RAMP: begin
        ml_next = lim_left;
        mr_next = lim_right;
      end
      ST_FOLLOW: begin
        ml_next = cmd_left;
        mr_next = cmd_right;
      end
      ST_SEARCH: begin
        if (last_dir == DIR_LEFT)
          mr_next = SEARCH_SPEED;
        else
          ml_next = SEARCH_SPEED;
      end
      default: ;
    endcase
    if (stop_req) begin
      ml_next = '0;
      mr_next = '0;
    end
  end

  always_comb begin
    state_next  = state;
    dir_next    = last_dir;
    lost_next   = (state == ST_FOLLOW) ? lost_cnt : '0;
    search_next = search_cnt;
    flag_next   = lost_flag;
    lim_load    = 1'b0;
    lim_step    = 1'b0;
    lim_val     = '0;
    if (stop_req) begin
      state_next  = ST_IDLE;
      lim_load    = 1'b1;
      lost_next   = '0;
      search_next = '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_next = ST_RAMP;
            lim_load   = 1'b1;
            flag_next  = 1'b0;
          end
        end
        ST_RAMP: begin
          lim_step = tick;
          if (limit == MAX_SPEED)
            state_next = ST_FOLLOW;
        end
        ST_FOLLOW: begin
          if (position == POS_LEFT)
            dir_next = DIR_LEFT;
          else if (position == POS_RIGHT)
            dir_next = DIR_RIGHT;
          if (position != POS_NONE) begin
            lost_next = '0;
          end else if (tick) begin
            lost_next = lost_cnt + 16'd1;
            if (lost_cnt + 16'd1 >= LOST_TICKS) begin
              state_next  = ST_SEARCH;
              search_next = '0;
              lost_next   = '0;
            end
          end
        end
        ST_SEARCH: begin
          // reacquire re-ramps from spin speed and beats timeout
          if (position != POS_NONE) begin
            state_next = ST_RAMP;
            lim_load   = 1'b1;
            lim_val    = SEARCH_SPEED;
          end else if (tick) begin
            search_next = search_cnt + 16'd1;
            if (search_cnt + 16'd1 >= SEARCH_TICKS) begin
              state_next = ST_HALT;
              flag_next  = 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign state_o = state;

endmodule
